link_anim_ctrl: RTL and testbench
=================================

# link_anim_ctrl

Sequencer for the player (Link) sprite: holds position and facing, steps the walking animation once per video frame, and picks which 32x32 direction/frame sprite ROM drives the pixel path. It also generates the shared ROM read address from the beam position and produces a hit flag aligned with the ROM's one-cycle read latency. It sits between the VGA timing generator and the per-sprite ROM/palette instances. A downstream mux uses `sprite_sel` and `sprite_hit` to overlay Link on the background.

## Interface
Parameters:
- `STEP`, 2: pixels moved per frame while walking.
- `ANIM_DIV`, 8: walking frames per animation toggle; must be at least 1.
- `X_INIT` / `Y_INIT`, 304 / 224: position after reset.
- `X_MAX` / `Y_MAX`, 608 / 448: largest legal top-left corner (screen size minus 32).

Ports:
- `vga_clk` in 1: single clock for the whole block.
- `Reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `move_valid` in 1: a movement key is held; sampled only on `frame_start`.
- `move_dir` in 2: 0 up, 1 down, 2 left, 3 right; sampled with `move_valid`.
- `DrawX`, `DrawY` in 10: current beam pixel.
- `blank` in 1: high means active video.
- `rom_q` in 4: palette index from the selected ROM, valid one cycle after `rom_address`.
- `pos_x`, `pos_y` out 10: sprite top-left corner, registered.
- `sprite_sel` out 3: {dir[1:0], frame}; right/frame0 = 6.
- `rom_address` out 10: combinational ROM address.
- `sprite_hit` out 1: the current `rom_q` is an opaque Link pixel.

## Operation
- The state machine has two states: IDLE and WALK. All state updates happen only in cycles where `frame_start`=1. In every other cycle `move_valid`/`move_dir` are ignored.
- IDLE:
  - `frame_start` with `move_valid`=1: dir <= `move_dir`, apply one step, anim counter <= 0, go to WALK. `frame` stays 0.
  - `frame_start` with `move_valid`=0: stay in IDLE; nothing changes.
- WALK, `frame_start` with `move_valid`=1:
  - Apply one step.
  - If `move_dir` equals the current dir: counter increments. When the counter equals `ANIM_DIV-1` it wraps to 0 and `frame` toggles.
  - If `move_dir` differs: dir <= `move_dir`, counter <= 0, `frame` is kept.
- WALK, `frame_start` with `move_valid`=0: go to IDLE, `frame` <= 0, counter <= 0. Dir and position are kept.
- Step arithmetic, with 10-bit position and clamped (saturating) results:
  - Up: `pos_y` = `pos_y` < STEP ? 0 : `pos_y` - STEP.
  - Down: `pos_y` = min(`pos_y` + STEP, Y_MAX).
  - Left and right: the same rule on `pos_x`, clamping at 0 and X_MAX.
  - The sum is computed in 11 bits so it cannot overflow.
- Address generation:
  - dx = `DrawX` - `pos_x` and dy = `DrawY` - `pos_y`, both 10-bit modulo.
  - in_sprite = (dx < 32) & (dy < 32). Underflow wraps to a large value, so a beam left of or above the sprite reads as outside.
  - `rom_address` = in_sprite ? {dy[4:0], dx[4:0]} : 0, i.e. dy*32 + dx.
- Hit flag:
  - in_sprite and `blank` are registered once, giving hit_d.
  - `sprite_hit` = hit_d & (`rom_q` != 0). Palette index 0 is transparent.
- Position and dir change only at `frame_start`, so no tearing occurs within a visible frame.

## Timing
- Reset values: `pos_x`=X_INIT, `pos_y`=Y_INIT, dir=3 (right), `frame`=0, `sprite_sel`=6, state IDLE, counter 0, hit_d 0, `sprite_hit`=0.
- `Reset` has priority over a simultaneous `frame_start`. Reset asserted mid-walk returns every register to its reset value on the next edge.
- State, position and `sprite_sel` update on the `vga_clk` edge that samples `frame_start`=1, and are visible the following cycle.
- `rom_address` has zero latency from `DrawX`/`DrawY`.
- `sprite_hit` is valid in cycle N+1 for the beam pixel of cycle N, aligned with `rom_q`.
- `sprite_hit` is 0 in any cycle whose registered `blank` was 0.
- A `frame_start` pulse held for k cycles counts as k events. The source must provide a single-cycle pulse; this is not guarded.

## Test plan
- Reset: assert `Reset` for 2 cycles, even with `frame_start`=1. Expect `pos_x`=304, `pos_y`=224, `sprite_sel`=6, `sprite_hit`=0.
- Single step: `frame_start` with `move_valid`=1, `move_dir`=3. Expect `pos_x`=306 next cycle, state WALK, `sprite_sel`=6. A `move_valid` pulse without `frame_start` leaves `pos_x` unchanged.
- Animation and stop:
  - 9 consecutive walking frames right (entry plus 8): `sprite_sel` goes from 6 to 7 on the 8th counted frame and `pos_x` reaches 322.
  - A then `frame_start` with `move_valid`=0 gives `sprite_sel`=6 and IDLE.
  - A left step gives `sprite_sel`=4, and `pos_x` decreases by 2.
- Clamp: from `pos_x`=607, step right, expect 608; step again, expect 608. From `pos_y`=1, step up, expect 0.
- Address and hit: `pos`=(304,224), `DrawX`=309, `DrawY`=227, `blank`=1.
  - Expect `rom_address`=101.
  - Next cycle `rom_q`=4 gives `sprite_hit`=1; `rom_q`=0 gives `sprite_hit`=0.
  - `DrawX`=303 gives `rom_address`=0 and `sprite_hit`=0 next cycle.
  - `DrawX`=335 is inside (dx=31); 336 is outside.
- Blanking: in-sprite beam with `blank`=0 and `rom_q`=5 gives `sprite_hit`=0 next cycle.

Source files
------------

// File: rtl/link_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : link_anim_ctrl
// Description : Player sprite sequencer. Frame-rate position, facing and walk
//               animation, plus beam-relative ROM addressing and hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module link_anim_ctrl #(
    parameter int STEP     = 2,
    parameter int ANIM_DIV = 8,
    parameter int X_INIT   = 304,
    parameter int Y_INIT   = 224,
    parameter int X_MAX    = 608,
    parameter int Y_MAX    = 448
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic [3:0] rom_q,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [2:0] sprite_sel,
    output logic [9:0] rom_address,
    output logic       sprite_hit
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [9:0]       c_step     = 10'(STEP);
    localparam logic [9:0]       c_x_init   = 10'(X_INIT);
    localparam logic [9:0]       c_y_init   = 10'(Y_INIT);
    localparam logic [10:0]      c_x_max    = 11'(X_MAX);
    localparam logic [10:0]      c_y_max    = 11'(Y_MAX);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ANIM_DIV - 1);
    localparam logic [1:0]       c_dir_init = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } state_t;

    state_t           r_state;
    logic [9:0]       r_pos_x;
    logic [9:0]       r_pos_y;
    logic [1:0]       r_dir;
    logic             r_frame;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hit_d;

    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic [9:0]  w_x_inc;
    logic [9:0]  w_y_inc;
    logic [9:0]  w_x_dec;
    logic [9:0]  w_y_dec;
    logic [9:0]  w_step_x;
    logic [9:0]  w_step_y;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_in_sprite;

    // Saturating step in both directions; sum is 11 bits so it cannot wrap.
    assign w_x_sum = {1'b0, r_pos_x} + {1'b0, c_step};
    assign w_y_sum = {1'b0, r_pos_y} + {1'b0, c_step};
    assign w_x_inc = (w_x_sum > c_x_max) ? c_x_max[9:0] : w_x_sum[9:0];
    assign w_y_inc = (w_y_sum > c_y_max) ? c_y_max[9:0] : w_y_sum[9:0];
    assign w_x_dec = (r_pos_x < c_step) ? 10'd0 : r_pos_x - c_step;
    assign w_y_dec = (r_pos_y < c_step) ? 10'd0 : r_pos_y - c_step;

    always_comb begin
        w_step_x = r_pos_x;
        w_step_y = r_pos_y;
        case (move_dir)
            2'd0:    w_step_y = w_y_dec;
            2'd1:    w_step_y = w_y_inc;
            2'd2:    w_step_x = w_x_dec;
            default: w_step_x = w_x_inc;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pos_x <= c_x_init;
            r_pos_y <= c_y_init;
            r_dir   <= c_dir_init;
            r_frame <= 1'b0;
            r_cnt   <= '0;
            r_hit_d <= 1'b0;
        end else begin
            r_hit_d <= w_in_sprite & blank;
            if (frame_start) begin
                case (r_state)
                    S_IDLE: begin
                        if (move_valid) begin
                            r_dir   <= move_dir;
                            r_pos_x <= w_step_x;
                            r_pos_y <= w_step_y;
                            r_cnt   <= '0;
                            r_state <= S_WALK;
                        end
                    end
                    default: begin
                        if (move_valid) begin
                            r_pos_x <= w_step_x;
                            r_pos_y <= w_step_y;
                            if (move_dir == r_dir) begin
                                if (r_cnt == c_cnt_last) begin
                                    r_cnt   <= '0;
                                    r_frame <= ~r_frame;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end else begin
                                // Turning keeps the leg pose, restarts the cadence
                                r_dir <= move_dir;
                                r_cnt <= '0;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_frame <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // Modulo subtraction: beam left of / above the sprite wraps large.
    assign w_dx        = DrawX - r_pos_x;
    assign w_dy        = DrawY - r_pos_y;
    assign w_in_sprite = (w_dx < 10'd32) && (w_dy < 10'd32);
    assign rom_address = w_in_sprite ? {w_dy[4:0], w_dx[4:0]} : 10'd0;

    assign sprite_hit = r_hit_d & (rom_q != 4'd0);
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign sprite_sel = {r_dir, r_frame};

endmodule
`default_nettype wire

// File: tb/tb_link_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_anim_ctrl
// Description : Bench for link_anim_ctrl: directed cases plus random frames
//               against a behavioural model of movement and beam hit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_anim_ctrl;

    localparam int STEP = 2, ANIM_DIV = 8, X_INIT = 304, Y_INIT = 224;
    localparam int X_MAX = 608, Y_MAX = 448;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       blank = 1'b0;
    logic [3:0] rom_q = 4'd0;
    logic [9:0] pos_x, pos_y, rom_address;
    logic [2:0] sprite_sel;
    logic       sprite_hit;

    link_anim_ctrl dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_start(frame_start),
        .move_valid(move_valid), .move_dir(move_dir), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .rom_q(rom_q), .pos_x(pos_x), .pos_y(pos_y),
        .sprite_sel(sprite_sel), .rom_address(rom_address), .sprite_hit(sprite_hit)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_px, m_py, m_dir, m_frame, m_cnt, m_walk, m_hitd;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap_off(input int beam, input int pos);
        return (beam - pos + 1024) % 1024;
    endfunction

    function automatic int inside_spr(input int bx, input int by, input int px, input int py);
        return (wrap_off(bx, px) < 32 && wrap_off(by, py) < 32) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_px = X_INIT; m_py = Y_INIT; m_dir = 3; m_frame = 0; m_cnt = 0;
        m_walk = 0; m_hitd = 0;
    endtask

    task automatic model_move(input int d);
        case (d)
            0: m_py = (m_py < STEP) ? 0 : m_py - STEP;
            1: m_py = (m_py + STEP > Y_MAX) ? Y_MAX : m_py + STEP;
            2: m_px = (m_px < STEP) ? 0 : m_px - STEP;
            default: m_px = (m_px + STEP > X_MAX) ? X_MAX : m_px + STEP;
        endcase
    endtask

    // Advance one clock and mirror the spec's frame-level rules in the model
    task automatic tick();
        int d;
        @(posedge vga_clk);
        d = int'(move_dir);
        if (Reset) begin
            model_reset();
        end else begin
            m_hitd = inside_spr(int'(DrawX), int'(DrawY), m_px, m_py) & int'(blank);
            if (frame_start) begin
                if (m_walk == 0) begin
                    if (move_valid) begin
                        m_dir = d; model_move(d); m_cnt = 0; m_walk = 1;
                    end
                end else if (move_valid) begin
                    model_move(d);
                    if (d == m_dir) begin
                        m_cnt = m_cnt + 1;
                        if (m_cnt == ANIM_DIV) begin
                            m_cnt = 0; m_frame = 1 - m_frame;
                        end
                    end else begin
                        m_dir = d; m_cnt = 0;
                    end
                end else begin
                    m_walk = 0; m_frame = 0; m_cnt = 0;
                end
            end
        end
        #1;
    endtask

    task automatic check_all();
        int ea;
        #1;
        ea = inside_spr(int'(DrawX), int'(DrawY), m_px, m_py) != 0 ?
             wrap_off(int'(DrawY), m_py) * 32 + wrap_off(int'(DrawX), m_px) : 0;
        chk("pos_x", int'(pos_x), m_px);
        chk("pos_y", int'(pos_y), m_py);
        chk("sprite_sel", int'(sprite_sel), m_dir * 2 + m_frame);
        chk("rom_address", int'(rom_address), ea);
        chk("sprite_hit", int'(sprite_hit), (m_hitd != 0 && rom_q != 4'd0) ? 1 : 0);
    endtask

    task automatic frame(input logic mv, input logic [1:0] md);
        frame_start = 1'b1; move_valid = mv; move_dir = md;
        tick();
        frame_start = 1'b0; move_valid = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        // Reset wins over a simultaneous frame_start
        Reset = 1'b1; frame_start = 1'b1; move_valid = 1'b1; move_dir = 2'd0;
        tick(); tick();
        Reset = 1'b0; frame_start = 1'b0; move_valid = 1'b0;
        check_all();
        chk("rst_pos_x", int'(pos_x), 304);
        chk("rst_pos_y", int'(pos_y), 224);
        chk("rst_sel", int'(sprite_sel), 6);
        chk("rst_hit", int'(sprite_hit), 0);

        // Address and hit at pos (304,224)
        DrawX = 10'd309; DrawY = 10'd227; blank = 1'b1; rom_q = 4'd0;
        check_all();
        chk("addr_101", int'(rom_address), 101);
        tick();
        rom_q = 4'd4; check_all();
        chk("hit_opaque", int'(sprite_hit), 1);
        rom_q = 4'd0; check_all();
        chk("hit_transp", int'(sprite_hit), 0);
        DrawX = 10'd303; check_all();
        chk("addr_left_out", int'(rom_address), 0);
        tick();
        rom_q = 4'd4; check_all();
        chk("hit_left_out", int'(sprite_hit), 0);
        DrawX = 10'd335; check_all();
        chk("addr_dx31", int'(rom_address), 127);
        tick(); check_all();
        chk("hit_dx31", int'(sprite_hit), 1);
        DrawX = 10'd336; check_all();
        chk("addr_dx32", int'(rom_address), 0);
        tick(); check_all();
        chk("hit_dx32", int'(sprite_hit), 0);
        DrawX = 10'd309; blank = 1'b0;
        tick();
        rom_q = 4'd5; check_all();
        chk("hit_blank", int'(sprite_hit), 0);
        blank = 1'b1;

        // Walking: single step, ignored move_valid, animation, stop, turn
        frame(1'b1, 2'd3);
        chk("step_x", int'(pos_x), 306);
        chk("step_sel", int'(sprite_sel), 6);
        move_valid = 1'b1; move_dir = 2'd2;
        tick(); move_valid = 1'b0; check_all();
        chk("no_fs_x", int'(pos_x), 306);
        for (int i = 0; i < 7; i++) frame(1'b1, 2'd3);
        chk("pre_toggle_sel", int'(sprite_sel), 6);
        frame(1'b1, 2'd3);
        chk("toggle_sel", int'(sprite_sel), 7);
        chk("walk_x", int'(pos_x), 322);
        frame(1'b0, 2'd3);
        chk("stop_sel", int'(sprite_sel), 6);
        frame(1'b1, 2'd2);
        chk("left_sel", int'(sprite_sel), 4);
        chk("left_x", int'(pos_x), 320);

        // Walls
        for (int i = 0; i < 160; i++) frame(1'b1, 2'd3);
        chk("clamp_x_max", int'(pos_x), 608);
        for (int i = 0; i < 120; i++) frame(1'b1, 2'd0);
        chk("clamp_y_min", int'(pos_y), 0);
        for (int i = 0; i < 240; i++) frame(1'b1, 2'd1);
        chk("clamp_y_max", int'(pos_y), 448);

        // Random frames, beam biased around the sprite
        for (int i = 0; i < 4000; i++) begin
            Reset       = ($urandom_range(0, 299) == 0);
            frame_start = ($urandom_range(0, 3) == 0);
            move_valid  = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 5) == 0) move_dir = 2'($urandom_range(0, 3));
            DrawX = 10'((m_px + int'($urandom_range(0, 40)) - 4 + 1024) % 1024);
            DrawY = 10'((m_py + int'($urandom_range(0, 40)) - 4 + 1024) % 1024);
            blank = ($urandom_range(0, 3) != 0);
            rom_q = 4'($urandom_range(0, 15));
            check_all();
            tick();
            rom_q = 4'($urandom_range(0, 15));
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
